wb_ram_arbiter: RTL and testbench

//  Two-master Wishbone B3 arbiter that shares the single RAM data port (wb_to_avalon_bridge -> LPDDR2)

---
 rtl/wb_ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_wb_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_arbiter.sv
`timescale 1ns/1ps
// Round-robin two-master Wishbone B3 arbiter sharing the RAM data port between ibus (m0) and dbus (m1).
// A grant is held for a whole bus cycle; a watchdog turns a hung slave access into err to the owner.
module wb_ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [2:0]        m0_cti_i,
    input  logic [1:0]        m0_bte_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic              m0_rty_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic [2:0]        m1_cti_i,
    input  logic [1:0]        m1_bte_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              m1_rty_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);
    localparam int SW = DW / 8;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    state_t        state_reg, state_next;
    logic          last_reg, last_next;
    logic          owner_reg, owner_next;
    logic [WW-1:0] wdog_reg, wdog_next;

    logic [AW-1:0] adr_m [2];
    logic [DW-1:0] dat_m [2];
    logic [SW-1:0] sel_m [2];
    logic [2:0]    cti_m [2];
    logic [1:0]    bte_m [2];
    logic [1:0]    we_m, cyc_m, stb_m;

    assign adr_m[0] = m0_adr_i;  assign adr_m[1] = m1_adr_i;
    assign dat_m[0] = m0_dat_i;  assign dat_m[1] = m1_dat_i;
    assign sel_m[0] = m0_sel_i;  assign sel_m[1] = m1_sel_i;
    assign cti_m[0] = m0_cti_i;  assign cti_m[1] = m1_cti_i;
    assign bte_m[0] = m0_bte_i;  assign bte_m[1] = m1_bte_i;
    assign we_m     = {m1_we_i, m0_we_i};
    assign cyc_m    = {m1_cyc_i, m0_cyc_i};
    assign stb_m    = {m1_stb_i, m0_stb_i};

    logic owning, own_cyc, resp, pending, expire;

    assign owning  = (state_reg == OWN0) || (state_reg == OWN1);
    assign own_cyc = cyc_m[owner_reg];

    // Request path is a pure mux so a dropped owner cyc reaches the slave in the same cycle.
    assign s_cyc_o = owning & own_cyc;
    assign s_stb_o = owning & stb_m[owner_reg];
    assign s_we_o  = owning & we_m[owner_reg];
    assign s_adr_o = owning ? adr_m[owner_reg] : '0;
    assign s_dat_o = owning ? dat_m[owner_reg] : '0;
    assign s_sel_o = owning ? sel_m[owner_reg] : '0;
    assign s_cti_o = owning ? cti_m[owner_reg] : '0;
    assign s_bte_o = owning ? bte_m[owner_reg] : '0;

    assign resp      = s_ack_i | s_err_i | s_rty_i;
    assign pending   = s_cyc_o & s_stb_o & ~resp;
    assign expire    = WDOG_EN && pending && (wdog_reg == WDOG_LAST);
    assign timeout_o = expire;

    always_comb begin
        grant_o = 2'b00;
        if (state_reg != IDLE) begin
            grant_o = owner_reg ? 2'b10 : 2'b01;
        end
    end

    logic [1:0] ack_v, err_v, rty_v;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic mine;
            assign mine      = owning && (owner_reg == 1'(gi));
            assign ack_v[gi] = mine & s_ack_i;
            assign err_v[gi] = mine & (s_err_i | expire);
            assign rty_v[gi] = mine & s_rty_i;
        end
    endgenerate

    assign m0_ack_o = ack_v[0];
    assign m0_err_o = err_v[0];
    assign m0_rty_o = rty_v[0];
    assign m1_ack_o = ack_v[1];
    assign m1_err_o = err_v[1];
    assign m1_rty_o = rty_v[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        owner_next = owner_reg;
        wdog_next  = '0;
        case (state_reg)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (cyc_m[0] && (!cyc_m[1] || last_reg)) begin
                    state_next = OWN0;
                    owner_next = 1'b0;
                end else if (cyc_m[1]) begin
                    state_next = OWN1;
                    owner_next = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end else if (expire) begin
                    state_next = ABORT;
                end else if (pending && WDOG_EN) begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_next = IDLE;
                    last_next  = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            owner_reg <= owner_next;
            wdog_reg  <= wdog_next;
        end
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
`timescale 1ns/1ps
// Bench for wb_ram_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against an ownership/stall-count model of the arbiter.
module tb_wb_ram_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [AW-1:0] adr  [2];
    logic [DW-1:0] wdat [2];
    logic [SW-1:0] sel  [2];
    logic [2:0]    cti  [2];
    logic [1:0]    bte  [2];
    logic [1:0]    we, cyc, stb;
    logic [DW-1:0] mdat [2];
    logic [1:0]    mack, merr, mrty;

    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;
    logic [SW-1:0] s_sel;
    logic          s_we, s_cyc, s_stb;
    logic [2:0]    s_cti;
    logic [1:0]    s_bte;
    logic          s_ack, s_err, s_rty;
    logic [1:0]    grant;
    logic          tmo;

    int checks, errors;
    int own, last, stall;
    bit abrt;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_sel_i(sel[0]), .m0_we_i(we[0]),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_cti_i(cti[0]), .m0_bte_i(bte[0]),
        .m0_dat_o(mdat[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_sel_i(sel[1]), .m1_we_i(we[1]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_cti_i(cti[1]), .m1_bte_i(bte[1]),
        .m1_dat_o(mdat[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .timeout_o(tmo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        own   = -1;
        abrt  = 1'b0;
        last  = 1;
        stall = 0;
    endtask

    // Compare at the falling edge, then advance the model to the state after the next rising edge.
    task automatic step_begin();
        bit owning, e_scyc, e_sstb, resp, pend, fire, mine;
        int o;
        logic [1:0] e_grant;
        @(negedge clk);
        if (!rst_n) model_reset();
        owning  = (own >= 0) && !abrt;
        o       = (own < 0) ? 0 : own;
        e_scyc  = owning && cyc[o];
        e_sstb  = owning && stb[o];
        resp    = s_ack || s_err || s_rty;
        pend    = e_scyc && e_sstb && !resp;
        fire    = pend && (stall == TMO - 1);
        e_grant = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
        chk("grant", 64'(grant), 64'(e_grant));
        chk("timeout", 64'(tmo), 64'(fire));
        chk("s_cyc", 64'(s_cyc), 64'(e_scyc));
        chk("s_stb", 64'(s_stb), 64'(e_sstb));
        chk("s_we", 64'(s_we), owning ? 64'(we[o]) : 64'd0);
        chk("s_adr", 64'(s_adr), owning ? 64'(adr[o]) : 64'd0);
        chk("s_dat", 64'(s_wdat), owning ? 64'(wdat[o]) : 64'd0);
        chk("s_sel", 64'(s_sel), owning ? 64'(sel[o]) : 64'd0);
        chk("s_cti", 64'(s_cti), owning ? 64'(cti[o]) : 64'd0);
        chk("s_bte", 64'(s_bte), owning ? 64'(bte[o]) : 64'd0);
        for (int i = 0; i < 2; i++) begin
            mine = owning && (own == i);
            chk(i == 0 ? "m0_ack" : "m1_ack", 64'(mack[i]), 64'(mine && s_ack));
            chk(i == 0 ? "m0_err" : "m1_err", 64'(merr[i]), 64'(mine && (s_err || fire)));
            chk(i == 0 ? "m0_rty" : "m1_rty", 64'(mrty[i]), 64'(mine && s_rty));
            if (rst_n) chk(i == 0 ? "m0_dat" : "m1_dat", 64'(mdat[i]), 64'(s_rdat));
        end
        if (rst_n) begin
            if (own < 0) begin
                if (cyc[0] && cyc[1]) own = 1 - last;
                else if (cyc[0])      own = 0;
                else if (cyc[1])      own = 1;
                stall = 0;
            end else if (!cyc[own]) begin
                last  = own;
                own   = -1;
                abrt  = 1'b0;
                stall = 0;
            end else if (fire) begin
                abrt  = 1'b1;
                stall = 0;
            end else begin
                stall = pend ? stall + 1 : 0;
            end
        end
    endtask

    task automatic step_end();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step_begin();
            step_end();
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; wdat[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
        end
        we = '0; cyc = '0; stb = '0;
        s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic w, input logic [2:0] c);
        cyc[i] = 1'b1; stb[i] = 1'b1; adr[i] = a; we[i] = w; cti[i] = c;
        sel[i] = '1; wdat[i] = 32'h1234_0000 | 32'(a);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int beats;
        bit sluggish;
        checks = 0;
        errors = 0;
        model_reset();
        idle_all();
        #2 rst_n = 1'b0;

        // Reset state
        cycles(3);
        rst_n = 1'b1;
        step_begin();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_scyc", 64'(s_cyc), 64'd0);
        chk("rst_acks", 64'({mack, merr, mrty}), 64'd0);
        chk("rst_timeout", 64'(tmo), 64'd0);
        step_end();

        // m0 single read, slave answers two cycles after the first strobe
        req(0, 32'h0000_0100, 1'b0, 3'b000);
        step_begin(); chk("t2_scyc_pre", 64'(s_cyc), 64'd0); step_end();
        step_begin();
        chk("t2_scyc", 64'(s_cyc), 64'd1);
        chk("t2_sadr", 64'(s_adr), 64'h100);
        chk("t2_grant", 64'(grant), 64'h1);
        step_end();
        cycles(1);
        s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
        step_begin();
        chk("t2_m0_ack", 64'(mack[0]), 64'd1);
        chk("t2_m0_dat", 64'(mdat[0]), 64'hDEAD_BEEF);
        chk("t2_m1_ack", 64'(mack[1]), 64'd0);
        step_end();
        idle_all();
        cycles(2);

        // Simultaneous requests after reset: m0 first, then m1, then m0 again
        apply_reset();
        req(0, 32'h10, 1'b0, 3'b000);
        req(1, 32'h20, 1'b1, 3'b000);
        step_begin(); chk("t3_grant_c0", 64'(grant), 64'h0); step_end();
        step_begin(); chk("t3_grant_c1", 64'(grant), 64'h1); step_end();
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step_begin(); chk("t3_grant_c2", 64'(grant), 64'h1); chk("t3_scyc_c2", 64'(s_cyc), 64'd0); step_end();
        step_begin(); chk("t3_grant_idle", 64'(grant), 64'h0); step_end();
        step_begin(); chk("t3_grant_m1", 64'(grant), 64'h2); step_end();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        cycles(1);
        req(0, 32'h30, 1'b0, 3'b000);
        req(1, 32'h40, 1'b0, 3'b000);
        step_begin(); chk("t3_grant_idle2", 64'(grant), 64'h0); step_end();
        step_begin(); chk("t3_grant_rr", 64'(grant), 64'h1); step_end();
        idle_all();
        cycles(2);

        // m1 4-beat incrementing burst while m0 waits
        req(1, 32'h200, 1'b0, 3'b010);
        step_begin(); step_end();
        req(0, 32'h500, 1'b0, 3'b000);
        s_ack = 1'b1;
        beats = 0;
        for (int b = 0; b < 4; b++) begin
            cti[1] = (b == 3) ? 3'b111 : 3'b010;
            s_rdat = 32'hA000_0000 | 32'(b);
            step_begin();
            chk("t4_grant", 64'(grant), 64'h2);
            chk("t4_m0_ack", 64'(mack[0]), 64'd0);
            if (mack[1]) beats++;
            step_end();
            adr[1] = adr[1] + 32'd4;
        end
        chk("t4_beats", 64'(beats), 64'd4);
        cyc[1] = 1'b0; stb[1] = 1'b0; s_ack = 1'b0;
        step_begin(); chk("t4_grant_end", 64'(grant), 64'h2); step_end();
        step_begin(); chk("t4_grant_idle", 64'(grant), 64'h0); step_end();
        step_begin(); chk("t4_grant_m0", 64'(grant), 64'h1); step_end();
        idle_all();
        cycles(2);

        // Watchdog expiry on the 16th strobe cycle
        req(0, 32'h300, 1'b0, 3'b000);
        cycles(1);
        for (int k = 1; k <= TMO; k++) begin
            step_begin();
            chk("t5_err", 64'(merr[0]), 64'(k == TMO));
            chk("t5_timeout", 64'(tmo), 64'(k == TMO));
            step_end();
        end
        step_begin();
        chk("t5_abort_scyc", 64'(s_cyc), 64'd0);
        chk("t5_abort_grant", 64'(grant), 64'h1);
        chk("t5_abort_err", 64'(merr[0]), 64'd0);
        step_end();
        cycles(1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        step_begin(); chk("t5_abort_hold", 64'(grant), 64'h1); step_end();
        step_begin(); chk("t5_idle", 64'(grant), 64'h0); step_end();

        // Same, but the ack lands on the expiry cycle
        req(0, 32'h304, 1'b0, 3'b000);
        cycles(1);
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO) begin
                s_ack = 1'b1; s_rdat = 32'h5A5A_0016;
            end
            step_begin();
            chk("t5b_err", 64'(merr[0]), 64'd0);
            chk("t5b_ack", 64'(mack[0]), 64'(k == TMO));
            chk("t5b_timeout", 64'(tmo), 64'd0);
            step_end();
        end
        s_ack = 1'b0;
        step_begin(); chk("t5b_scyc", 64'(s_cyc), 64'd1); chk("t5b_grant", 64'(grant), 64'h1); step_end();
        idle_all();
        cycles(2);

        // Asynchronous reset pulse in the middle of a burst
        req(1, 32'h600, 1'b1, 3'b010);
        s_ack = 1'b1;
        cycles(1);
        step_begin();
        chk("t6_scyc_before", 64'(s_cyc), 64'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_scyc", 64'(s_cyc), 64'd0);
        chk("t6_sstb", 64'(s_stb), 64'd0);
        chk("t6_grant", 64'(grant), 64'h0);
        chk("t6_ack", 64'(mack[1]), 64'd0);
        step_end();
        idle_all();
        rst_n = 1'b1;
        cycles(2);

        // Random traffic: alternate responsive and sluggish slave phases
        for (int n = 0; n < 4000; n++) begin
            sluggish = ((n / 400) % 2) == 1;
            for (int i = 0; i < 2; i++) begin
                if (cyc[i]) begin
                    if ($urandom_range(sluggish ? 39 : 7, 0) == 0) begin
                        cyc[i] = 1'b0; stb[i] = 1'b0;
                    end else begin
                        stb[i] = sluggish ? ($urandom_range(15, 0) != 0) : ($urandom_range(3, 0) != 0);
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    cyc[i] = 1'b1; stb[i] = 1'b1;
                end
                adr[i]  = $urandom;
                wdat[i] = $urandom;
                sel[i]  = SW'($urandom);
                we[i]   = 1'($urandom);
                cti[i]  = 3'($urandom);
                bte[i]  = 2'($urandom);
            end
            s_rdat = $urandom;
            s_ack  = $urandom_range(99, 0) < (sluggish ? 2 : 40);
            s_err  = !sluggish && ($urandom_range(49, 0) == 0);
            s_rty  = !sluggish && ($urandom_range(59, 0) == 0);
            step_begin();
            step_end();
        end
        idle_all();
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
